// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: keycodes, operation and state
// encodings, datapath widths and the keycode-to-operation decode.
package calc_pkg;

  localparam int VAL_W     = 10;
  localparam int PROD_W    = 20;
  localparam int MAX_VALUE = 999;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_CALC    = 3'd2,
    S_RESULT  = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  function automatic op_t key_to_op(input logic [3:0] key);
    case (key)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

  function automatic logic [VAL_W-1:0] append_digit(input logic [VAL_W-1:0] value,
                                                    input logic [3:0] digit);
    logic [13:0] t;
    t = {4'b0, value} * 14'd10 + {10'b0, digit};
    return VAL_W'(t);
  endfunction

endpackage

// File: rtl/calc_seq_alu.sv
// Iterative multiply/divide unit: one setup edge on start, then ten steps.
// done and result are presented combinationally during the final step.
module calc_seq_alu
  import calc_pkg::*;
(
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  op_t               op,
  input  logic [VAL_W-1:0]  a,
  input  logic [VAL_W-1:0]  b,
  output logic              done,
  output logic [PROD_W-1:0] result,
  output logic              div_zero
);

  localparam logic [3:0] LAST_STEP = 4'(VAL_W - 1);

  logic              active;
  logic              is_div;
  logic [3:0]        step;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] mcand;
  logic [VAL_W-1:0]  mplier;
  logic [VAL_W-1:0]  rem;
  logic [VAL_W-1:0]  quo;
  logic [VAL_W-1:0]  dvsr;

  logic [PROD_W-1:0] prod_n;
  logic [VAL_W:0]    shifted;
  logic [VAL_W:0]    diff;
  logic              fits;
  logic [VAL_W-1:0]  rem_n;
  logic [VAL_W-1:0]  quo_n;

  // One shift-add step and one restoring-division step, both always computed.
  always_comb begin
    prod_n  = prod + (mplier[0] ? mcand : '0);
    shifted = {rem, quo[VAL_W-1]};
    diff    = shifted - {1'b0, dvsr};
    fits    = (shifted >= {1'b0, dvsr});
    rem_n   = fits ? VAL_W'(diff) : VAL_W'(shifted);
    quo_n   = {quo[VAL_W-2:0], fits};
  end

  assign done   = active && (step == LAST_STEP);
  assign result = is_div ? {{(PROD_W-VAL_W){1'b0}}, quo_n} : prod_n;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      is_div   <= 1'b0;
      step     <= '0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      div_zero <= 1'b0;
    end else if (abort) begin
      active   <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      // A zero divisor is flagged right away and never starts iterating.
      div_zero <= (op == OP_DIV) && (b == '0);
      active   <= !((op == OP_DIV) && (b == '0));
      is_div   <= (op == OP_DIV);
      step     <= '0;
      prod     <= '0;
      mcand    <= {{(PROD_W-VAL_W){1'b0}}, a};
      mplier   <= b;
      rem      <= '0;
      quo      <= a;
      dvsr     <= b;
    end else begin
      div_zero <= 1'b0;
      if (active) begin
        prod   <= prod_n;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        rem    <= rem_n;
        quo    <= quo_n;
        step   <= step + 4'd1;
        if (step == LAST_STEP) active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calculator_controller.sv
// Keypad calculator sequencer: builds two decimal operands from key events,
// runs the selected operation and drives the registered display value and flags.
module calculator_controller #(
  parameter int MAX_VALUE = calc_pkg::MAX_VALUE,
  parameter int DIGITS    = 3
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] keycode,
  input  logic       key_pressed,
  output logic [9:0] display_value,
  output logic       negative,
  output logic       error,
  output logic       busy,
  output logic [2:0] state_out
);

  import calc_pkg::*;

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0]  MAX_DIGITS = CNT_W'(DIGITS);
  localparam logic [PROD_W-1:0] MAX_W      = PROD_W'(MAX_VALUE);

  state_t           state, state_n;
  op_t              op, op_n;
  logic [VAL_W-1:0] a, a_n, b, b_n, res, res_n, disp_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             neg_n, err_n;
  logic             kp_q;

  logic              ev;
  logic              is_digit;
  logic              is_op;
  logic [VAL_W:0]    sum;
  logic              alu_start;
  logic              alu_abort;
  logic              alu_done;
  logic              alu_div_zero;
  logic [PROD_W-1:0] alu_result;

  assign ev       = key_pressed & ~kp_q;
  assign is_digit = (keycode <= 4'd9);
  assign is_op    = (keycode >= KEY_ADD) && (keycode <= KEY_DIV);
  assign sum      = {1'b0, a} + {1'b0, b};
  assign busy      = (state == S_CALC);
  assign state_out = state;

  calc_seq_alu u_alu (
    .Clk      (Clk),
    .reset    (reset),
    .start    (alu_start),
    .abort    (alu_abort),
    .op       (op),
    .a        (a),
    .b        (b),
    .done     (alu_done),
    .result   (alu_result),
    .div_zero (alu_div_zero)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state         <= S_ENTER_A;
      op            <= OP_ADD;
      a             <= '0;
      b             <= '0;
      res           <= '0;
      cnt           <= '0;
      negative      <= 1'b0;
      error         <= 1'b0;
      display_value <= '0;
      kp_q          <= 1'b0;
    end else begin
      state         <= state_n;
      op            <= op_n;
      a             <= a_n;
      b             <= b_n;
      res           <= res_n;
      cnt           <= cnt_n;
      negative      <= neg_n;
      error         <= err_n;
      display_value <= disp_n;
      kp_q          <= key_pressed;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op;
    a_n       = a;
    b_n       = b;
    res_n     = res;
    cnt_n     = cnt;
    neg_n     = negative;
    err_n     = error;
    alu_start = 1'b0;
    alu_abort = 1'b0;
    disp_n    = '0;

    if (ev && keycode == KEY_CLR) begin
      state_n   = S_ENTER_A;
      op_n      = OP_ADD;
      a_n       = '0;
      b_n       = '0;
      res_n     = '0;
      cnt_n     = '0;
      neg_n     = 1'b0;
      err_n     = 1'b0;
      alu_abort = 1'b1;
    end else begin
      case (state)
        S_ENTER_A: begin
          if (ev && is_digit) begin
            if (cnt < MAX_DIGITS) begin
              a_n   = append_digit(a, keycode);
              cnt_n = cnt + CNT_W'(1);
            end
          end else if (ev && is_op) begin
            op_n    = key_to_op(keycode);
            b_n     = '0;
            cnt_n   = '0;
            state_n = S_ENTER_B;
          end else if (ev && keycode == KEY_EQ) begin
            res_n   = a;
            neg_n   = 1'b0;
            state_n = S_RESULT;
          end
        end
        S_ENTER_B: begin
          if (ev && is_digit) begin
            if (cnt < MAX_DIGITS) begin
              b_n   = append_digit(b, keycode);
              cnt_n = cnt + CNT_W'(1);
            end
          end else if (ev && is_op) begin
            op_n = key_to_op(keycode);
          end else if (ev && keycode == KEY_EQ) begin
            alu_start = (op == OP_MUL) || (op == OP_DIV);
            state_n   = S_CALC;
          end
        end
        S_CALC: begin
          case (op)
            OP_ADD: begin
              if ({{(PROD_W-VAL_W-1){1'b0}}, sum} > MAX_W) begin
                state_n = S_ERROR;
                err_n   = 1'b1;
                res_n   = '0;
              end else begin
                res_n   = sum[VAL_W-1:0];
                neg_n   = 1'b0;
                state_n = S_RESULT;
              end
            end
            OP_SUB: begin
              res_n   = (b > a) ? (b - a) : (a - b);
              neg_n   = (b > a);
              state_n = S_RESULT;
            end
            default: begin
              if (alu_div_zero) begin
                state_n = S_ERROR;
                err_n   = 1'b1;
                res_n   = '0;
              end else if (alu_done) begin
                if (alu_result > MAX_W) begin
                  state_n = S_ERROR;
                  err_n   = 1'b1;
                  res_n   = '0;
                end else begin
                  res_n   = alu_result[VAL_W-1:0];
                  neg_n   = 1'b0;
                  state_n = S_RESULT;
                end
              end
            end
          endcase
        end
        S_RESULT: begin
          if (ev && is_digit) begin
            a_n     = {{(VAL_W-4){1'b0}}, keycode};
            b_n     = '0;
            cnt_n   = CNT_W'(1);
            neg_n   = 1'b0;
            state_n = S_ENTER_A;
          end else if (ev && is_op && !negative) begin
            // Chain: a non-negative result becomes the next left operand.
            a_n     = res;
            op_n    = key_to_op(keycode);
            b_n     = '0;
            cnt_n   = '0;
            state_n = S_ENTER_B;
          end
        end
        S_ERROR: begin
        end
        default: state_n = S_ENTER_A;
      endcase
    end

    case (state_n)
      S_ENTER_A: disp_n = a_n;
      S_ENTER_B: disp_n = b_n;
      S_CALC:    disp_n = b_n;
      S_RESULT:  disp_n = res_n;
      default:   disp_n = '0;
    endcase
  end

endmodule

// File: tb/tb_calculator_controller.sv
// Directed bench for calculator_controller: key sequences with hand-computed
// display values, flags and edge-accurate calculation latencies.
module tb_calculator_controller;

  logic       Clk = 1'b0;
  logic       reset;
  logic [3:0] keycode;
  logic       key_pressed;
  logic [9:0] display_value;
  logic       negative;
  logic       error;
  logic       busy;
  logic [2:0] state_out;

  int testsRun    = 0;
  int testsFailed = 0;
  int busyCycles;

  always #5 Clk = ~Clk;

  calculator_controller #(.MAX_VALUE(999), .DIGITS(3)) dut (
    .Clk           (Clk),
    .reset         (reset),
    .keycode       (keycode),
    .key_pressed   (key_pressed),
    .display_value (display_value),
    .negative      (negative),
    .error         (error),
    .busy          (busy),
    .state_out     (state_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Press for one cycle, release for one; returns on the negedge after the event edge.
  task automatic applyStimulus(input logic [3:0] key);
    @(negedge Clk);
    keycode     = key;
    key_pressed = 1'b1;
    @(negedge Clk);
    key_pressed = 1'b0;
  endtask

  task automatic enterKeys(input string seq);
    for (int i = 0; i < seq.len(); i++) begin
      byte c;
      c = seq[i];
      applyStimulus((c >= "A") ? 4'(c - "A" + 10) : 4'(c - "0"));
    end
  endtask

  task automatic waitWhileBusy(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 50) begin
      cycles++;
      @(negedge Clk);
    end
  endtask

  initial begin
    reset       = 1'b0;
    keycode     = 4'h0;
    key_pressed = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("rstDisplay", 32'(display_value), 0);
    checkOutput("rstNegative", 32'(negative), 0);
    checkOutput("rstError", 32'(error), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstState", 32'(state_out), 0);
    reset = 1'b1;

    enterKeys("12A34");
    checkOutput("addEntryB", 32'(display_value), 34);
    checkOutput("addEntryState", 32'(state_out), 1);
    enterKeys("E");
    waitWhileBusy(busyCycles);
    checkOutput("addCycles", 32'(busyCycles), 1);
    checkOutput("addResult", 32'(display_value), 46);
    checkOutput("addNegative", 32'(negative), 0);
    checkOutput("addState", 32'(state_out), 3);

    enterKeys("C2E");
    waitWhileBusy(busyCycles);
    checkOutput("chainMulCycles", 32'(busyCycles), 10);
    checkOutput("chainMulResult", 32'(display_value), 92);

    enterKeys("5");
    checkOutput("resultDigit", 32'(display_value), 5);
    checkOutput("resultDigitState", 32'(state_out), 0);
    enterKeys("B9E");
    waitWhileBusy(busyCycles);
    checkOutput("subCycles", 32'(busyCycles), 1);
    checkOutput("subMagnitude", 32'(display_value), 4);
    checkOutput("subNegative", 32'(negative), 1);
    enterKeys("A");
    checkOutput("negOpState", 32'(state_out), 3);
    checkOutput("negOpDisplay", 32'(display_value), 4);
    checkOutput("negOpNegative", 32'(negative), 1);

    enterKeys("F5B5E");
    waitWhileBusy(busyCycles);
    checkOutput("subEqualResult", 32'(display_value), 0);
    checkOutput("subEqualNegative", 32'(negative), 0);

    enterKeys("F25C40E");
    waitWhileBusy(busyCycles);
    checkOutput("mulOvfCycles", 32'(busyCycles), 10);
    checkOutput("mulOvfState", 32'(state_out), 4);
    checkOutput("mulOvfError", 32'(error), 1);
    checkOutput("mulOvfDisplay", 32'(display_value), 0);
    enterKeys("3");
    checkOutput("errorIgnoresDigit", 32'(state_out), 4);
    enterKeys("F");
    checkOutput("clearState", 32'(state_out), 0);
    checkOutput("clearError", 32'(error), 0);
    checkOutput("clearDisplay", 32'(display_value), 0);
    checkOutput("clearBusy", 32'(busy), 0);

    enterKeys("100D7E");
    waitWhileBusy(busyCycles);
    checkOutput("divCycles", 32'(busyCycles), 10);
    checkOutput("divResult", 32'(display_value), 14);
    checkOutput("divState", 32'(state_out), 3);

    enterKeys("F7D0E");
    checkOutput("divZeroBusy", 32'(busy), 1);
    waitWhileBusy(busyCycles);
    checkOutput("divZeroCycles", 32'(busyCycles), 1);
    checkOutput("divZeroState", 32'(state_out), 4);
    checkOutput("divZeroError", 32'(error), 1);

    enterKeys("F999A1E");
    waitWhileBusy(busyCycles);
    checkOutput("addOvfCycles", 32'(busyCycles), 1);
    checkOutput("addOvfState", 32'(state_out), 4);

    enterKeys("F1234");
    checkOutput("digitLimit", 32'(display_value), 123);

    enterKeys("F");
    @(negedge Clk);
    keycode     = 4'h7;
    key_pressed = 1'b1;
    repeat (1000) @(negedge Clk);
    checkOutput("heldKeyDisplay", 32'(display_value), 7);
    key_pressed = 1'b0;
    enterKeys("2");
    checkOutput("heldKeyOneEvent", 32'(display_value), 72);

    enterKeys("F9C9E");
    repeat (3) @(negedge Clk);
    enterKeys("F");
    checkOutput("abortState", 32'(state_out), 0);
    checkOutput("abortBusy", 32'(busy), 0);
    checkOutput("abortDisplay", 32'(display_value), 0);
    repeat (15) @(negedge Clk);
    checkOutput("abortLateState", 32'(state_out), 0);
    checkOutput("abortLateDisplay", 32'(display_value), 0);

    enterKeys("9C9E");
    repeat (3) @(negedge Clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("asyncRstBusy", 32'(busy), 0);
    checkOutput("asyncRstState", 32'(state_out), 0);
    checkOutput("asyncRstDisplay", 32'(display_value), 0);
    @(negedge Clk);
    reset = 1'b1;
    repeat (15) @(negedge Clk);
    checkOutput("rstLateState", 32'(state_out), 0);
    checkOutput("rstLateDisplay", 32'(display_value), 0);
    enterKeys("3C3E");
    waitWhileBusy(busyCycles);
    checkOutput("restartCycles", 32'(busyCycles), 10);
    checkOutput("restartResult", 32'(display_value), 9);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
